// File: rtl/shift_reg_store_stream_pkg.sv
// Shared types and helpers for the multi-lane stream shift-register store.
// The controller decodes one op_e per cycle and broadcasts it to every lane.
package shift_reg_store_stream_pkg;

  typedef enum logic [2:0] {
    OpIdle,
    OpClear,
    OpLoad,
    OpRot,
    OpShift
  } op_e;

  function automatic int unsigned count_w(int unsigned len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/shift_reg_store_stream_if.sv
// Input/output stream handshake bundle for the shift-register store.
// slave = the store, master = producer on the input plus consumer on the output.
interface shift_reg_store_stream_if #(
  parameter int unsigned Bits     = 8,
  parameter int unsigned Channels = 1
);

  logic                               in_valid;
  logic                               in_ready;
  logic [Channels-1:0][Bits-1:0]      in_data;
  logic                               out_valid;
  logic                               out_ready;
  logic [Channels-1:0][Bits-1:0]      out_data;

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

endinterface

// File: rtl/shift_reg_store_stream_lane.sv
// One lane of the store: Length words of Bits, index 0 newest.
// All sequencing decisions arrive pre-decoded as op_i from the shared controller.
module shift_reg_store_stream_lane
  import shift_reg_store_stream_pkg::*;
#(
  parameter int unsigned Bits   = 8,
  parameter int unsigned Length = 4
) (
  input  logic                         clk_i,
  input  op_e                          op_i,
  input  logic [Bits-1:0]              rst_val_i,
  input  logic [Length-1:0][Bits-1:0]  load_col_i,
  input  logic [Bits-1:0]              in_word_i,
  output logic [Length-1:0][Bits-1:0]  store_o
);

  logic [Length-1:0][Bits-1:0] store_d, store_q;

  always_comb begin
    store_d = store_q;
    unique case (op_i)
      OpClear: begin
        for (int k = 0; k < Length; k++) store_d[k] = rst_val_i;
      end
      OpLoad: store_d = load_col_i;
      OpRot: begin
        store_d[0] = store_q[Length-1];
        for (int k = 1; k < Length; k++) store_d[k] = store_q[k-1];
      end
      OpShift: begin
        store_d[0] = in_word_i;
        for (int k = 1; k < Length; k++) store_d[k] = store_q[k-1];
      end
      default: ;
    endcase
  end

  // Reset is folded into op_i (OpClear) by the controller.
  always_ff @(posedge clk_i) begin
    store_q <= store_d;
  end

  assign store_o = store_q;

endmodule

// File: rtl/shift_reg_store_stream.sv
// Multi-channel stream shift-register store: Channels lanes of Length x Bits with a shared
// controller providing occupancy, parallel load, clear and circular rotate.
module shift_reg_store_stream
  import shift_reg_store_stream_pkg::*;
#(
  parameter int unsigned Bits     = 8,
  parameter int unsigned Length   = 4,
  parameter int unsigned Channels = 1,
  localparam int unsigned CntW    = count_w(Length),
  localparam int unsigned PosW    = $clog2(Length)
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic [Bits-1:0]                          rst_val_i,
  input  logic                                     clear_i,
  input  logic                                     load_i,
  input  logic [Length-1:0][Channels-1:0][Bits-1:0] load_data_i,
  input  logic                                     rot_en_i,
  shift_reg_store_stream_if.slave                  strm,
  output logic [Length-1:0][Channels-1:0][Bits-1:0] store_o,
  output logic [CntW-1:0]                          count_o,
  output logic                                     full_o,
  output logic                                     rot_wrap_o
);

  localparam logic [CntW-1:0] CntFull = CntW'(Length);
  localparam logic [PosW-1:0] PosMax  = PosW'(Length - 1);

  logic [CntW-1:0] count_d, count_q;
  logic [PosW-1:0] rot_pos_d, rot_pos_q;
  logic            rot_wrap_d, rot_wrap_q;
  logic            full, in_ready, in_fire;
  op_e             op;

  always_comb begin
    full     = (count_q == CntFull);
    // Once full, a new word may only enter if the oldest one can leave.
    in_ready = ~rst_i & ~clear_i & ~load_i & ~(rot_en_i & full) & (~full | strm.out_ready);
    in_fire  = strm.in_valid & in_ready;

    if (rst_i || clear_i)       op = OpClear;
    else if (load_i)            op = OpLoad;
    else if (rot_en_i && full)  op = OpRot;
    else if (in_fire)           op = OpShift;
    else                        op = OpIdle;

    count_d    = count_q;
    rot_pos_d  = rot_pos_q;
    rot_wrap_d = 1'b0;
    unique case (op)
      OpClear: begin
        count_d   = '0;
        rot_pos_d = '0;
      end
      OpLoad: begin
        count_d   = CntFull;
        rot_pos_d = '0;
      end
      OpRot: begin
        rot_wrap_d = (rot_pos_q == PosMax);
        rot_pos_d  = (rot_pos_q == PosMax) ? '0 : rot_pos_q + PosW'(1);
      end
      OpShift: begin
        rot_pos_d = '0;
        if (!full) count_d = count_q + CntW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q    <= '0;
      rot_pos_q  <= '0;
      rot_wrap_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      rot_pos_q  <= rot_pos_d;
      rot_wrap_q <= rot_wrap_d;
    end
  end

  for (genvar c = 0; c < Channels; c++) begin : g_lane
    logic [Length-1:0][Bits-1:0] load_col;
    logic [Length-1:0][Bits-1:0] lane_store;

    for (genvar k = 0; k < Length; k++) begin : g_word
      assign load_col[k]   = load_data_i[k][c];
      assign store_o[k][c] = lane_store[k];
    end

    shift_reg_store_stream_lane #(
      .Bits   (Bits),
      .Length (Length)
    ) u_lane (
      .clk_i      (clk_i),
      .op_i       (op),
      .rst_val_i  (rst_val_i),
      .load_col_i (load_col),
      .in_word_i  (strm.in_data[c]),
      .store_o    (lane_store)
    );

    assign strm.out_data[c] = lane_store[Length-1];
  end

  assign strm.in_ready  = in_ready;
  assign strm.out_valid = full & ~rot_en_i & ~load_i & ~clear_i & ~rst_i;
  assign count_o        = count_q;
  assign full_o         = full;
  assign rot_wrap_o     = rot_wrap_q;

endmodule

// File: tb/tb_shift_reg_store_stream.sv
// Bench for shift_reg_store_stream (Bits=8, Length=4, Channels=2): directed scenarios then
// random control traffic, all checked against a queue-based window model.
module tb_shift_reg_store_stream;

  localparam int unsigned Bits = 8;
  localparam int unsigned Length = 4;
  localparam int unsigned Channels = 2;
  localparam logic [7:0] RstVal = 8'hAA;

  logic clk;
  logic rst, clr, ld, rot, ival, oready;
  logic [Channels-1:0][Bits-1:0] din;
  logic [Length-1:0][Channels-1:0][Bits-1:0] ldat;
  logic [Length-1:0][Channels-1:0][Bits-1:0] store;
  logic [2:0] count;
  logic full, wrap;

  shift_reg_store_stream_if #(.Bits(Bits), .Channels(Channels)) bus ();

  assign bus.in_valid  = ival;
  assign bus.in_data   = din;
  assign bus.out_ready = oready;

  shift_reg_store_stream #(
    .Bits     (Bits),
    .Length   (Length),
    .Channels (Channels)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .rst_val_i   (RstVal),
    .clear_i     (clr),
    .load_i      (ld),
    .load_data_i (ldat),
    .rot_en_i    (rot),
    .strm        (bus),
    .store_o     (store),
    .count_o     (count),
    .full_o      (full),
    .rot_wrap_o  (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Window model: queue element 0 is the newest word (both lanes packed, lane 0 low).
  logic [15:0] mq[$];
  int m_cnt, m_pos, n_checks, n_errors, n_pops;
  bit m_wrap;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq = {};
    repeat (Length) mq.push_back({RstVal, RstVal});
    m_cnt = 0;
    m_pos = 0;
  endtask

  task automatic check_regs();
    logic [63:0] exp_store;
    for (int k = 0; k < Length; k++) exp_store[k*16 +: 16] = mq[k];
    chk("store", store, exp_store);
    chk("count", count, m_cnt);
    chk("full", full, m_cnt == Length);
    chk("rot_wrap", wrap, m_wrap);
  endtask

  // One clock: check combinational handshake, advance model at the edge, check registers.
  task automatic tick();
    bit mfull, rdy, ov;
    #3;
    mfull = (m_cnt == Length);
    rdy = !rst && !clr && !ld && !(rot && mfull) && (mfull ? oready : 1'b1);
    ov  = mfull && !rot && !ld && !clr && !rst;
    chk("in_ready", bus.in_ready, rdy);
    chk("out_valid", bus.out_valid, ov);
    if (ov) chk("out_data", bus.out_data, mq[Length-1]);
    @(posedge clk);
    m_wrap = 0;
    if (rst || clr) begin
      model_clear();
    end else if (ld) begin
      for (int k = 0; k < Length; k++) mq[k] = ldat[k];
      m_cnt = Length;
      m_pos = 0;
    end else if (rot && mfull) begin
      mq.push_front(mq.pop_back());
      m_wrap = (m_pos == Length - 1);
      m_pos = (m_pos + 1) % Length;
    end else if (ival && rdy) begin
      mq.push_front(din);
      void'(mq.pop_back());
      if (m_cnt < Length) m_cnt++;
      m_pos = 0;
      if (ov && oready) n_pops++;
    end
    #1;
    check_regs();
  endtask

  task automatic idle_inputs();
    rst = 0; clr = 0; ld = 0; rot = 0; ival = 0; oready = 0; din = '0;
  endtask

  initial begin
    n_checks = 0; n_errors = 0; n_pops = 0; m_wrap = 0;
    idle_inputs();
    ldat = '0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    model_clear();
    check_regs();

    // Fill with 1..4 (lane 1 = +16) while the consumer stalls.
    for (int i = 1; i <= 4; i++) begin
      ival = 1; din = {8'(i + 16), 8'(i)};
      tick();
    end
    din = {8'd99, 8'd98};
    tick();
    chk("stalled_count", count, 3'd4);

    // Full with consumer ready: 5 enters, 1 leaves.
    din = {8'd21, 8'd5}; oready = 1;
    #3;
    chk("pop_word", bus.out_data, {8'd17, 8'd1});
    tick();
    chk("after_pop", store, {8'd18, 8'd2, 8'd19, 8'd3, 8'd20, 8'd4, 8'd21, 8'd5});

    // Four rotations return to the same window, wrap pulses once.
    ival = 1; oready = 1; rot = 1;
    repeat (4) tick();
    rot = 0; ival = 0;
    tick();
    chk("rot_home", store, {8'd18, 8'd2, 8'd19, 8'd3, 8'd20, 8'd4, 8'd21, 8'd5});

    // Load beats a simultaneous input; rotation restarts from origin.
    ldat = {$urandom(), $urandom()};
    ld = 1; ival = 1; din = 16'h1234;
    tick();
    ld = 0; ival = 0; rot = 1;
    repeat (4) tick();
    rot = 0;
    tick();

    // Clear mid-fill drops the input; rot_en below full is ignored.
    clr = 1;
    tick();
    clr = 0; ival = 1;
    for (int i = 0; i < 2; i++) begin
      din = 16'($urandom());
      tick();
    end
    clr = 1;
    tick();
    clr = 0;
    chk("clear_count", count, 3'd0);
    for (int i = 0; i < 3; i++) begin
      din = 16'($urandom());
      tick();
    end
    rot = 1; din = 16'h5A5A;
    tick();
    chk("rot_ignored", count, 3'd4);
    rot = 0;

    // Random control traffic.
    for (int n = 0; n < 800; n++) begin
      rst    = ($urandom_range(0, 99) == 0);
      clr    = ($urandom_range(0, 39) == 0);
      ld     = ($urandom_range(0, 24) == 0);
      rot    = ($urandom_range(0, 3) == 0);
      ival   = ($urandom_range(0, 3) != 0);
      oready = $urandom_range(0, 1) != 0;
      din    = 16'($urandom());
      ldat   = {$urandom(), $urandom()};
      tick();
    end
    idle_inputs();
    tick();
    if (n_pops == 0) chk("pops_seen", 64'(n_pops), 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
